// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the EX-stage integer divide unit: funct3 codes,
// divider FSM state type and the default datapath width.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } idiv_state_t;

endpackage

// File: rtl/ex_idiv_unit_if.sv
// ID/EX-side request and EX/MEM-side result signals of the divide unit.
interface ex_idiv_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
);
  logic            IDiv_I;
  logic [2:0]      Funct3_I;
  logic [XLEN-1:0] rs1_val_I;
  logic [XLEN-1:0] rs2_val_I;
  logic [4:0]      id_ex_rd;
  logic            flush_I;
  logic            stall_O;
  logic            done_O;
  logic [XLEN-1:0] result_O;
  logic [4:0]      rd_O;

  modport master (
    output IDiv_I, Funct3_I, rs1_val_I, rs2_val_I, id_ex_rd, flush_I,
    input  stall_O, done_O, result_O, rd_O
  );

  modport slave (
    input  IDiv_I, Funct3_I, rs1_val_I, rs2_val_I, id_ex_rd, flush_I,
    output stall_O, done_O, result_O, rd_O
  );
endinterface

// File: rtl/ex_idiv_unit_core.sv
// Radix-2 restoring divider datapath (unsigned magnitudes): remainder,
// quotient, divisor and iteration counter, with next-step values exposed.
module idiv_core #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next,
  output logic            last
);
  logic [XLEN-1:0]  rem_q, quo_q, div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    shifted, diff;

  // Partial remainder kept one bit wider so divisors with the MSB set compare correctly.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, div_q};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b0};
    end
    last = (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
      cnt_q <= CNT_W'(XLEN);
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end
endmodule

// File: rtl/ex_idiv_unit.sv
// EX-stage RV32M DIV/DIVU/REM/REMU unit: FSM, sign handling, stall/done.
// Optional zero/overflow/small-quotient early completion: IDIV_EARLY_OUT_EN.
module ex_idiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic         CLK,
  input  logic         rst,
  ex_idiv_unit_if.slave bus
);
  idiv_state_t     state;
  logic            is_signed, is_rem, a_neg, b_neg, start;
  logic [XLEN-1:0] mag_a, mag_b, quo_next, rem_next, q_fix, r_fix, fin_result;
  logic            last;
  logic            is_rem_q, q_neg_q, r_neg_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q, rd_hold;

  always_comb begin
    is_signed = (bus.Funct3_I == FUNCT3_DIV) || (bus.Funct3_I == FUNCT3_REM);
    is_rem    = (bus.Funct3_I == FUNCT3_REM) || (bus.Funct3_I == FUNCT3_REMU);
    a_neg     = is_signed & bus.rs1_val_I[XLEN-1];
    b_neg     = is_signed & bus.rs2_val_I[XLEN-1];
    mag_a     = a_neg ? -bus.rs1_val_I : bus.rs1_val_I;
    mag_b     = b_neg ? -bus.rs2_val_I : bus.rs2_val_I;
    start     = (state == IDLE) & bus.IDiv_I & ~bus.flush_I;
    q_fix     = q_neg_q ? -quo_next : quo_next;
    r_fix     = r_neg_q ? -rem_next : rem_next;
    fin_result = is_rem_q ? r_fix : q_fix;
  end

`ifdef IDIV_EARLY_OUT_EN
  logic            eo_zero, eo_ovf, eo_hit;
  logic [XLEN-1:0] eo_result;

  always_comb begin
    eo_zero = (bus.rs2_val_I == '0);
    eo_ovf  = is_signed & (bus.rs1_val_I == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2_val_I == '1);
    eo_hit  = eo_zero | eo_ovf | (mag_b > mag_a);
    if (is_rem) eo_result = eo_ovf ? '0 : bus.rs1_val_I;
    else        eo_result = eo_zero ? '1 : (eo_ovf ? bus.rs1_val_I : '0);
  end
`endif

  idiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk      (CLK),
    .rst      (rst),
    .load     (start),
    .step     ((state == CALC) & ~bus.flush_I),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_next (quo_next),
    .rem_next (rem_next),
    .last     (last)
  );

  // Result is registered on the final CALC step so done_O coincides with FINISH.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      rd_hold  <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          is_rem_q <= is_rem;
          q_neg_q  <= (a_neg ^ b_neg) & (bus.rs2_val_I != '0);
          r_neg_q  <= a_neg;
          rd_hold  <= bus.id_ex_rd;
`ifdef IDIV_EARLY_OUT_EN
          if (eo_hit) begin
            state    <= FINISH;
            done_q   <= 1'b1;
            result_q <= eo_result;
            rd_q     <= bus.id_ex_rd;
          end else begin
            state <= CALC;
          end
`else
          state <= CALC;
`endif
        end
        CALC: if (bus.flush_I) begin
          state <= IDLE;
        end else if (last) begin
          state    <= FINISH;
          done_q   <= 1'b1;
          result_q <= fin_result;
          rd_q     <= rd_hold;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_O  = start | (state == CALC);
  assign bus.done_O   = done_q;
  assign bus.result_O = result_q;
  assign bus.rd_O     = rd_q;
endmodule

// File: tb/tb_ex_idiv_unit.sv
// Directed bench for ex_idiv_unit: vector table plus flush/reset sequences.
module tb_ex_idiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_idiv_unit_if #(.XLEN(32)) bus ();
  ex_idiv_unit #(.XLEN(32)) dut (.CLK(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          eo;
  } vec_t;

  vec_t vecs[18];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output bit stall_ok);
    bus.IDiv_I    = 1'b1;
    bus.Funct3_I  = f3;
    bus.rs1_val_I = a;
    bus.rs2_val_I = b;
    bus.id_ex_rd  = rd;
    #1;
    stall_ok = (bus.stall_O === 1'b1);
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done_O === 1'b1) break;
      if (bus.stall_O !== 1'b1) stall_ok = 1'b0;
    end
    if (bus.stall_O !== 1'b0) stall_ok = 1'b0;
    res = bus.result_O;
    rdo = bus.rd_O;
    bus.IDiv_I = 1'b0;
  endtask

  function automatic int exp_lat(input bit eo);
`ifdef IDIV_EARLY_OUT_EN
    return eo ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  initial begin
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    bit          stall_ok;
    bit          seen_done;

    vecs[0]  = '{3'b100, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{3'b110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{3'b111, 32'hFFFFFFF9,   32'd2,          32'h00000001,   1'b0};
    vecs[3]  = '{3'b101, 32'h00001234,   32'd0,          32'hFFFFFFFF,   1'b1};
    vecs[4]  = '{3'b110, 32'h00001234,   32'd0,          32'h00001234,   1'b1};
    vecs[5]  = '{3'b100, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1'b1};
    vecs[6]  = '{3'b100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1};
    vecs[7]  = '{3'b110, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1'b1};
    vecs[8]  = '{3'b101, 32'd9,          32'd3,          32'd3,          1'b0};
    vecs[9]  = '{3'b100, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0};
    vecs[10] = '{3'b110, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   1'b0};
    vecs[11] = '{3'b101, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          1'b0};
    vecs[12] = '{3'b111, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          1'b0};
    vecs[13] = '{3'b111, 32'd5,          32'd9,          32'd5,          1'b1};
    vecs[14] = '{3'b100, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0};
    vecs[15] = '{3'b110, 32'd7,          32'hFFFFFFFE,   32'd1,          1'b0};
    vecs[16] = '{3'b110, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1'b1};
    vecs[17] = '{3'b101, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b1};

    rst = 1'b1;
    bus.IDiv_I = 1'b0; bus.Funct3_I = '0; bus.rs1_val_I = '0; bus.rs2_val_I = '0;
    bus.id_ex_rd = '0; bus.flush_I = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done",   32'(bus.done_O),  32'd0);
    check("reset_result", bus.result_O,     32'd0);
    check("reset_rd",     32'(bus.rd_O),    32'd0);
    check("reset_stall",  32'(bus.stall_O), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), res, rdo, lat, stall_ok);
      check($sformatf("v%0d_result", i),  res,            vecs[i].exp);
      check($sformatf("v%0d_rd", i),      32'(rdo),       32'(i + 1));
      check($sformatf("v%0d_latency", i), 32'(lat),       32'(exp_lat(vecs[i].eo)));
      check($sformatf("v%0d_stall", i),   32'(stall_ok),  32'd1);
      @(posedge clk); #1;
    end

    // Request coinciding with flush in IDLE is dropped.
    bus.IDiv_I = 1'b1; bus.flush_I = 1'b1;
    bus.Funct3_I = 3'b100; bus.rs1_val_I = 32'd100; bus.rs2_val_I = 32'd7; bus.id_ex_rd = 5'd30;
    #1;
    check("idle_flush_stall", 32'(bus.stall_O), 32'd0);
    @(posedge clk); #1;
    bus.IDiv_I = 1'b0; bus.flush_I = 1'b0;
    #1;
    check("idle_flush_nostart", 32'(bus.stall_O | bus.done_O), 32'd0);
    @(posedge clk); #1;

    // Flush at cycle 10 of a DIV, then an immediate DIVU 9/3.
    bus.IDiv_I = 1'b1; bus.Funct3_I = 3'b100;
    bus.rs1_val_I = 32'd100; bus.rs2_val_I = 32'd7; bus.id_ex_rd = 5'd20;
    repeat (10) begin @(posedge clk); #1; end
    bus.flush_I = 1'b1;
    #1;
    check("flush_c10_stall", 32'(bus.stall_O), 32'd1);
    @(posedge clk); #1;
    bus.flush_I = 1'b0; bus.IDiv_I = 1'b0;
    #1;
    check("flush_c11_stall", 32'(bus.stall_O), 32'd0);
    check("flush_c11_done",  32'(bus.done_O),  32'd0);
    run_op(3'b101, 32'd9, 32'd3, 5'd9, res, rdo, lat, stall_ok);
    check("b2b_result",  res,       32'd3);
    check("b2b_rd",      32'(rdo),  32'd9);
    check("b2b_latency", 32'(lat),  32'd33);
    @(posedge clk); #1;

    // Reset at cycle 15 of a DIV.
    bus.IDiv_I = 1'b1; bus.Funct3_I = 3'b100;
    bus.rs1_val_I = 32'd100; bus.rs2_val_I = 32'd7; bus.id_ex_rd = 5'd21;
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b1; bus.IDiv_I = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_done",   32'(bus.done_O),  32'd0);
    check("rst_mid_result", bus.result_O,     32'd0);
    check("rst_mid_rd",     32'(bus.rd_O),    32'd0);
    check("rst_mid_stall",  32'(bus.stall_O), 32'd0);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done_O === 1'b1) seen_done = 1'b1;
    end
    check("rst_mid_no_done", 32'(seen_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
